// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared types, widths and channel-bus pack/unpack helpers for delay_line_mc
package delay_line_pkg;
  localparam int N_DEF = 16;
  localparam int DW_DEF = 24;
  localparam int CH_DEF = 2;
  typedef logic [$clog2(N_DEF)-1:0] ptr_t;
  function automatic int sum_width(input int dw, input int n);
    return dw + $clog2(n);
  endfunction
  localparam int SW_DEF = sum_width(DW_DEF, N_DEF);
  function automatic logic [CH_DEF*DW_DEF-1:0] pack_data(input logic signed [DW_DEF-1:0] s [CH_DEF]);
    logic [CH_DEF*DW_DEF-1:0] b;
    for (int c = 0; c < CH_DEF; c++) b[c*DW_DEF +: DW_DEF] = s[c];
    return b;
  endfunction
  function automatic logic signed [DW_DEF-1:0] unpack_data(input logic [CH_DEF*DW_DEF-1:0] b, input int c);
    return b[c*DW_DEF +: DW_DEF];
  endfunction
  function automatic logic signed [SW_DEF-1:0] unpack_sum(input logic [CH_DEF*SW_DEF-1:0] b, input int c);
    return b[c*SW_DEF +: SW_DEF];
  endfunction
endpackage

// File: rtl/delay_line_chan.sv
// delay_line_chan: one channel's circular storage, two masked taps, D=1 bypass and running-sum registers
module delay_line_chan import delay_line_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DATA_WIDTH = DW_DEF,
  parameter int SUM_WIDTH = sum_width(DW_DEF, N_DEF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic [$clog2(N)-1:0]        wr_ptr,
  input  logic [$clog2(N)-1:0]        rd0,
  input  logic [$clog2(N)-1:0]        rd1,
  input  logic                        use0,
  input  logic                        use1,
  input  logic                        byp,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic signed [SUM_WIDTH-1:0]  sum
);
  logic [DATA_WIDTH-1:0] mem [N];
  logic signed [DATA_WIDTH-1:0] tap0, tap1;
  always_comb begin
    tap0 = use0 ? mem[rd0] : '0;
    tap1 = byp ? din : use1 ? mem[rd1] : '0;
  end
  // taps read the pre-write contents, so tap D at wr_ptr still sees the oldest sample
  always_ff @(posedge clk)
    if (en && !rst) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      dout <= '0;
      sum <= '0;
    end else if (en) begin
      dout <= tap1;
      sum <= (clr ? '0 : sum) + SUM_WIDTH'(din) - SUM_WIDTH'(tap0);
    end else if (clr) begin
      dout <= '0;
      sum <= '0;
    end
endmodule

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel programmable-depth delay line with running sums over the last D samples
module delay_line_mc import delay_line_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DATA_WIDTH = DW_DEF,
  parameter int CHANNELS = CH_DEF,
  parameter int SUM_WIDTH = sum_width(DATA_WIDTH, N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [$clog2(N):0]             delay,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [CHANNELS*SUM_WIDTH-1:0]  sum_out,
  output logic                           primed,
  output logic                           delay_err
);
  localparam int PW = $clog2(N);
  localparam int FW = PW + 1;
  localparam logic [FW-1:0] NF = FW'(N);
  logic [PW-1:0] wr_ptr, rd0, rd1;
  logic [FW-1:0] fill, delay_q, d_eff, f_eff, fill_nx;
  logic chg, use0, use1, byp;
  // a delay change takes effect before any sample accepted in the same cycle
  always_comb begin
    delay_err = delay == '0 || delay > NF;
    chg = !delay_err && delay != delay_q;
    d_eff = chg ? delay : delay_q;
    f_eff = chg ? '0 : fill;
    fill_nx = f_eff == NF ? NF : f_eff + 1'b1;
    use0 = f_eff >= d_eff;
    use1 = f_eff >= d_eff - 1'b1;
    byp = d_eff == FW'(1);
    rd0 = wr_ptr - d_eff[PW-1:0];
    rd1 = rd0 + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      fill <= '0;
      delay_q <= NF;
      primed <= 1'b0;
    end else begin
      if (chg) delay_q <= delay;
      if (en) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill <= fill_nx;
        primed <= fill_nx >= d_eff;
      end else if (chg) begin
        fill <= '0;
        primed <= 1'b0;
      end
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    delay_line_chan #(.N(N), .DATA_WIDTH(DATA_WIDTH), .SUM_WIDTH(SUM_WIDTH)) u_chan (
      .clk(clk), .rst(rst), .en(en), .clr(chg),
      .wr_ptr(wr_ptr), .rd0(rd0), .rd1(rd1),
      .use0(use0), .use1(use1), .byp(byp),
      .din(data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout(data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .sum(sum_out[i*SUM_WIDTH +: SUM_WIDTH])
    );
  end
endmodule

// File: tb/tb_delay_line_mc.sv
// tb_delay_line_mc: scoreboard bench comparing delay_line_mc against a sample-history reference model
module tb_delay_line_mc;
  import delay_line_pkg::*;
  localparam int N = 16;
  localparam int DW = 24;
  localparam int CH = 2;
  localparam int SW = sum_width(DW, N);
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [4:0] delay = '0;
  logic [CH*DW-1:0] data_in = '0;
  logic [CH*DW-1:0] data_out;
  logic [CH*SW-1:0] sum_out;
  logic primed, delay_err;
  always #5 clk = ~clk;
  delay_line_mc #(.N(N), .DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .delay(delay), .data_in(data_in),
    .data_out(data_out), .sum_out(sum_out), .primed(primed), .delay_err(delay_err)
  );
  typedef struct {int d0; int d1; int s0; int s1; logic p; logic e;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int hist0[$], hist1[$];
  int mdq = N;
  int checks = 0, errors = 0;
  function automatic int tap(input int q[$], input int d);
    int idx = q.size() - d;
    return idx >= 0 ? q[idx] : 0;
  endfunction
  function automatic int wsum(input int q[$], input int d);
    int acc = 0;
    for (int j = (q.size() > d ? q.size() - d : 0); j < q.size(); j++) acc += q[j];
    return acc;
  endfunction
  task automatic model_clear();
    hist0.delete();
    hist1.delete();
    cur.d0 = 0; cur.d1 = 0; cur.s0 = 0; cur.s1 = 0; cur.p = 1'b0;
  endtask
  task automatic step(input logic r, input logic e, input int d, input int v0, input int v1);
    logic signed [DW-1:0] s [CH];
    @(negedge clk);
    rst = r; en = e; delay = 5'(d);
    s[0] = DW'(v0); s[1] = DW'(v1);
    data_in = pack_data(s);
    cur.e = (d == 0 || d > N);
    if (r) begin
      mdq = N;
      model_clear();
    end else begin
      if (!cur.e && d != mdq) begin
        mdq = d;
        model_clear();
      end
      if (e) begin
        hist0.push_back(v0);
        hist1.push_back(v1);
        cur.d0 = tap(hist0, mdq);
        cur.d1 = tap(hist1, mdq);
        cur.s0 = wsum(hist0, mdq);
        cur.s1 = wsum(hist1, mdq);
        cur.p = hist0.size() >= mdq;
      end
    end
    sb.push_back(cur);
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks += 6;
      if (int'(unpack_data(data_out, 0)) !== x.d0) begin errors++; $display("FAIL sb_dout0 got %0d exp %0d", int'(unpack_data(data_out, 0)), x.d0); end
      if (int'(unpack_data(data_out, 1)) !== x.d1) begin errors++; $display("FAIL sb_dout1 got %0d exp %0d", int'(unpack_data(data_out, 1)), x.d1); end
      if (int'(unpack_sum(sum_out, 0)) !== x.s0) begin errors++; $display("FAIL sb_sum0 got %0d exp %0d", int'(unpack_sum(sum_out, 0)), x.s0); end
      if (int'(unpack_sum(sum_out, 1)) !== x.s1) begin errors++; $display("FAIL sb_sum1 got %0d exp %0d", int'(unpack_sum(sum_out, 1)), x.s1); end
      if (primed !== x.p) begin errors++; $display("FAIL sb_primed got %b exp %b", primed, x.p); end
      if (delay_err !== x.e) begin errors++; $display("FAIL sb_delay_err got %b exp %b", delay_err, x.e); end
    end
  end
  task automatic test_reset();
    step(1'b1, 1'b0, 16, 0, 0);
    step(1'b1, 1'b1, 16, 5, -5);
    checks++;
    if (data_out !== '0 || sum_out !== '0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got dout=%h sum=%h primed=%b exp all 0", data_out, sum_out, primed);
    end
  endtask
  task automatic test_ramp();
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 16, k, -k);
      if (k == 14) begin
        checks++;
        if (int'(unpack_data(data_out, 0)) !== 0 || primed !== 1'b0) begin errors++; $display("FAIL ramp_k14 got dout=%0d primed=%b exp 0 0", int'(unpack_data(data_out, 0)), primed); end
      end
      if (k == 15) begin
        checks++;
        if (int'(unpack_data(data_out, 0)) !== 0 || primed !== 1'b1) begin errors++; $display("FAIL ramp_k15 got dout=%0d primed=%b exp 0 1", int'(unpack_data(data_out, 0)), primed); end
      end
      if (k == 16) begin
        checks++;
        if (int'(unpack_data(data_out, 0)) !== 1) begin errors++; $display("FAIL ramp_k16 got %0d exp 1", int'(unpack_data(data_out, 0))); end
      end
    end
    checks++;
    if (int'(unpack_sum(sum_out, 0)) !== 184 || int'(unpack_sum(sum_out, 1)) !== -184) begin
      errors++;
      $display("FAIL ramp_sum got %0d/%0d exp 184/-184", int'(unpack_sum(sum_out, 0)), int'(unpack_sum(sum_out, 1)));
    end
  endtask
  task automatic test_d1_toggle();
    int last = 0;
    for (int i = 0; i < 10; i++) begin
      int v = i * 37 - 100;
      step(1'b0, (i % 2) == 0, 1, v, 3 * v);
      if (i % 2 == 0) last = v;
      checks++;
      if (int'(unpack_data(data_out, 0)) !== last || int'(unpack_sum(sum_out, 0)) !== last) begin
        errors++;
        $display("FAIL d1_hold i=%0d got dout=%0d sum=%0d exp %0d", i, int'(unpack_data(data_out, 0)), int'(unpack_sum(sum_out, 0)), last);
      end
    end
  endtask
  task automatic test_d4();
    int vin [5] = '{100, -50, 7, 3, -200};
    int esum [5] = '{100, 50, 57, 60, -240};
    int eout [5] = '{0, 0, 0, 100, -50};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4, vin[i], -vin[i]);
      checks++;
      if (int'(unpack_sum(sum_out, 0)) !== esum[i] || int'(unpack_data(data_out, 0)) !== eout[i]) begin
        errors++;
        $display("FAIL d4_seq i=%0d got sum=%0d dout=%0d exp %0d %0d", i, int'(unpack_sum(sum_out, 0)), int'(unpack_data(data_out, 0)), esum[i], eout[i]);
      end
    end
  endtask
  task automatic test_delay_change();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16, 50 + i, -50 - i);
    step(1'b0, 1'b1, 3, 9, -9);
    checks++;
    if (int'(unpack_sum(sum_out, 0)) !== 9 || int'(unpack_data(data_out, 0)) !== 0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL chg_first got sum=%0d dout=%0d primed=%b exp 9 0 0", int'(unpack_sum(sum_out, 0)), int'(unpack_data(data_out, 0)), primed);
    end
    step(1'b0, 1'b1, 3, 4, -4);
    checks++;
    if (primed !== 1'b0) begin errors++; $display("FAIL chg_primed1 got %b exp 0", primed); end
    step(1'b0, 1'b1, 3, 2, -2);
    checks++;
    if (primed !== 1'b1) begin errors++; $display("FAIL chg_primed2 got %b exp 1", primed); end
  endtask
  task automatic test_illegal();
    step(1'b0, 1'b1, 0, 20, -20);
    checks++;
    if (delay_err !== 1'b1 || primed !== 1'b1) begin errors++; $display("FAIL illegal_0 got err=%b primed=%b exp 1 1", delay_err, primed); end
    step(1'b0, 1'b1, 17, 30, -30);
    checks++;
    if (delay_err !== 1'b1 || int'(unpack_data(data_out, 0)) !== 2) begin errors++; $display("FAIL illegal_17 got err=%b dout=%0d exp 1 2", delay_err, int'(unpack_data(data_out, 0))); end
    step(1'b0, 1'b1, 3, 40, -40);
    step(1'b0, 1'b0, 0, 41, -41);
  endtask
  task automatic test_reset_mid();
    int nz = 0;
    step(1'b1, 1'b1, 5, 77, -77);
    checks++;
    if (data_out !== '0 || sum_out !== '0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got dout=%h sum=%h primed=%b exp all 0", data_out, sum_out, primed);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16, 1000 + i, -i - 1);
      if (i < 15 && int'(unpack_data(data_out, 0)) != 0) nz++;
    end
    checks++;
    if (nz != 0 || int'(unpack_data(data_out, 0)) !== 1000 || primed !== 1'b1) begin
      errors++;
      $display("FAIL reset_mask got nonzero=%0d dout=%0d primed=%b exp 0 1000 1", nz, int'(unpack_data(data_out, 0)), primed);
    end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_d1_toggle();
    test_d4();
    test_delay_change();
    test_illegal();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end
endmodule
